// File: rtl/reg_bank_dumper_if.sv
// Byte-stream and bank read-port signals for the register bank dumper.
// master: the dumper (drives rs, tx_data/tx_valid, busy, done).
// slave:  the environment (bank read data, start request, byte sink ready).
interface reg_bank_dumper_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  start;
  logic [DATA_WIDTH-1:0] regdata;
  logic                  tx_ready;
  logic [4:0]            rs;
  logic [7:0]            tx_data;
  logic                  tx_valid;
  logic                  busy;
  logic                  done;

  modport master (
    input  start, regdata, tx_ready,
    output rs, tx_data, tx_valid, busy, done
  );

  modport slave (
    output start, regdata, tx_ready,
    input  rs, tx_data, tx_valid, busy, done
  );
endinterface

// File: rtl/reg_bank_dumper.sv
// Register bank dumper: on a start pulse, reads registers 0..NUM_REGS-1 through
// the bank's registered read port and streams each word LSB-byte first over a
// valid/ready byte interface.
// Optional: define REG_BANK_DUMPER_HEADER_EN to send a 0xA5 header byte
// before register 0.
module reg_bank_dumper #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32
) (
  input  logic              clk,
  input  logic              rst,
  reg_bank_dumper_if.master bus
);

  localparam int              NUM_BYTES   = DATA_WIDTH / 8;
  localparam int              IDX_W       = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_BYTES - 1);
  localparam logic [4:0]      LAST_RS     = 5'(NUM_REGS - 1);
  localparam logic [7:0]      HEADER_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    LOAD,
    SEND,
`ifdef REG_BANK_DUMPER_HEADER_EN
    HEADER,
`endif
    DONE
  } state_t;

  state_t                state_reg;
  state_t                state_next;
  logic [4:0]            rs_reg;
  logic [IDX_W-1:0]      byte_idx;
  logic [DATA_WIDTH-1:0] word_reg;

  logic accept;
  logic last_byte;
  logic last_reg;

  // tx_valid is a pure function of state, so accept never loops back into it.
  assign accept    = bus.tx_valid && bus.tx_ready;
  assign last_byte = (byte_idx == LAST_IDX);
  assign last_reg  = (rs_reg == LAST_RS);

  // State register; reset aborts any dump in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
`ifdef REG_BANK_DUMPER_HEADER_EN
          state_next = HEADER;
`else
          state_next = ADDR;
`endif
        end
      end
`ifdef REG_BANK_DUMPER_HEADER_EN
      HEADER:  if (accept) state_next = ADDR;
`endif
      ADDR:    state_next = LOAD;   // bank latches rs at the end of this cycle
      LOAD:    state_next = SEND;   // regdata is valid now, captured at the edge
      SEND: begin
        if (accept && last_byte) state_next = last_reg ? DONE : ADDR;
      end
      DONE:    state_next = IDLE;   // start is deliberately not looked at here
      default: state_next = IDLE;
    endcase
  end

  // Datapath: register index, captured word (shifted down per byte), byte counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rs_reg   <= '0;
      byte_idx <= '0;
      word_reg <= '0;
    end else begin
      case (state_reg)
        LOAD: begin
          word_reg <= bus.regdata;
          byte_idx <= '0;
        end
        SEND: begin
          if (accept) begin
            if (last_byte) begin
              // Final byte of the word: step to the next register, or back to 0 when finished.
              rs_reg <= last_reg ? 5'd0 : rs_reg + 5'd1;
            end else begin
              byte_idx <= byte_idx + IDX_W'(1);
              word_reg <= word_reg >> 8;
            end
          end
        end
        IDLE, DONE: rs_reg <= '0;
        default: ;
      endcase
    end
  end

  // Outputs decoded from state; tx_data is forced to 0 whenever no byte is offered.
  always_comb begin
    bus.rs       = rs_reg;
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    bus.busy     = 1'b1;
    bus.done     = 1'b0;
    case (state_reg)
      IDLE: bus.busy = 1'b0;
      SEND: begin
        bus.tx_valid = 1'b1;
        bus.tx_data  = word_reg[7:0];
      end
`ifdef REG_BANK_DUMPER_HEADER_EN
      HEADER: begin
        bus.tx_valid = 1'b1;
        bus.tx_data  = HEADER_BYTE;
      end
`endif
      DONE: begin
        bus.busy = 1'b0;
        bus.done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
